// File: rtl/vedic_mult_pipe.sv
// vedic_mult_pipe: 2-stage Urdhva Tiryakbhyam multiplier, WIDTH x WIDTH -> 2*WIDTH product.
// Latency: 2 CLK cycles from input transfer to OUT_VALID; one product per cycle when unstalled.
// Backpressure: IN_READY = !OUT_VALID | OUT_READY; when low both stages hold their contents.
// Optional feature: define VEDIC_SIGNED_EN to add the SIGNED port (two's-complement mode).

// vedic_cell: combinational recursive Urdhva Tiryakbhyam multiplier, W x W -> 2*W.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; used only inside vedic_mult_pipe stage 1.
module vedic_cell #(
   parameter int W = 2
) (
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic [2*W-1:0] p
);
   generate
      if (W == 2) begin : g_leaf
         // 2x2 cell: vertical LSB, crosswise middle bit, vertical MSB plus cross carry
         logic s0;
         logic x_lo;
         logic x_hi;
         logic c1;
         logic hh;
         assign s0   = a[0] & b[0];
         assign x_lo = a[1] & b[0];
         assign x_hi = a[0] & b[1];
         assign c1   = x_lo & x_hi;
         assign hh   = a[1] & b[1];
         assign p    = {hh & c1, hh ^ c1, x_lo ^ x_hi, s0};
      end else begin : g_split
         localparam int H = W / 2;
         logic [W-1:0] ll;
         logic [W-1:0] hl;
         logic [W-1:0] lh;
         logic [W-1:0] hh;
         logic [W:0]   mid;
         vedic_cell #(.W(H)) u_ll (.a(a[H-1:0]), .b(b[H-1:0]), .p(ll));
         vedic_cell #(.W(H)) u_hl (.a(a[W-1:H]), .b(b[H-1:0]), .p(hl));
         vedic_cell #(.W(H)) u_lh (.a(a[H-1:0]), .b(b[W-1:H]), .p(lh));
         vedic_cell #(.W(H)) u_hh (.a(a[W-1:H]), .b(b[W-1:H]), .p(hh));
         // crosswise terms share one carry bit, then land H bits up
         assign mid = {1'b0, hl} + {1'b0, lh};
         assign p   = {hh, ll} + {{(W-H-1){1'b0}}, mid, {H{1'b0}}};
      end
   endgenerate
endmodule

module vedic_mult_pipe #(
   parameter int WIDTH = 8
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic               IN_VALID,
   output logic               IN_READY,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
`ifdef VEDIC_SIGNED_EN
   input  logic               SIGNED,
`endif
   output logic               OUT_VALID,
   input  logic               OUT_READY,
   output logic [2*WIDTH-1:0] P,
   output logic               BUSY
);
   localparam int H = WIDTH / 2;

   logic               advance;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic               in_neg;
   logic [WIDTH-1:0]   sp_ll;
   logic [WIDTH-1:0]   sp_hl;
   logic [WIDTH-1:0]   sp_lh;
   logic [WIDTH-1:0]   sp_hh;

   logic               s1_vld;
   logic               s1_neg;
   logic [WIDTH-1:0]   s1_ll;
   logic [WIDTH-1:0]   s1_hl;
   logic [WIDTH-1:0]   s1_lh;
   logic [WIDTH-1:0]   s1_hh;

   logic [WIDTH:0]     mid;
   logic [2*WIDTH-1:0] mag;
   logic [2*WIDTH-1:0] prod;

   // A pipeline slot opens whenever the output register is empty or being drained
   assign advance  = !OUT_VALID | OUT_READY;
   assign IN_READY = advance;
   assign BUSY     = s1_vld | OUT_VALID;

`ifdef VEDIC_SIGNED_EN
   // Signed mode multiplies magnitudes; the sign is restored after the final sum.
   // The most negative value maps to its own bit pattern, which is the correct unsigned magnitude.
   assign a_mag  = (SIGNED && A[WIDTH-1]) ? -A : A;
   assign b_mag  = (SIGNED && B[WIDTH-1]) ? -B : B;
   assign in_neg = SIGNED & (A[WIDTH-1] ^ B[WIDTH-1]);
`else
   assign a_mag  = A;
   assign b_mag  = B;
   assign in_neg = 1'b0;
`endif

   vedic_cell #(.W(H)) u_ll (.a(a_mag[H-1:0]),     .b(b_mag[H-1:0]),     .p(sp_ll));
   vedic_cell #(.W(H)) u_hl (.a(a_mag[WIDTH-1:H]), .b(b_mag[H-1:0]),     .p(sp_hl));
   vedic_cell #(.W(H)) u_lh (.a(a_mag[H-1:0]),     .b(b_mag[WIDTH-1:H]), .p(sp_lh));
   vedic_cell #(.W(H)) u_hh (.a(a_mag[WIDTH-1:H]), .b(b_mag[WIDTH-1:H]), .p(sp_hh));

   // Final recombination of the registered sub-products, then optional negate
   assign mid  = {1'b0, s1_hl} + {1'b0, s1_lh};
   assign mag  = {s1_hh, s1_ll} + {{(WIDTH-H-1){1'b0}}, mid, {H{1'b0}}};
   assign prod = s1_neg ? -mag : mag;

   // Stage 1: bubbles clear only the valid bit; sub-products load on accepted operands
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         s1_vld <= 1'b0;
         s1_neg <= 1'b0;
         s1_ll  <= '0;
         s1_hl  <= '0;
         s1_lh  <= '0;
         s1_hh  <= '0;
      end else if (advance) begin
         s1_vld <= IN_VALID;
         if (IN_VALID) begin
            s1_neg <= in_neg;
            s1_ll  <= sp_ll;
            s1_hl  <= sp_hl;
            s1_lh  <= sp_lh;
            s1_hh  <= sp_hh;
         end
      end
   end

   // Stage 2: P only moves when a valid entry arrives, so bubbles leave it untouched
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         OUT_VALID <= 1'b0;
         P         <= '0;
      end else if (advance) begin
         OUT_VALID <= s1_vld;
         if (s1_vld) begin
            P <= prod;
         end
      end
   end
endmodule

// File: tb/tb_vedic_mult_pipe.sv
`timescale 1ns/1ps
module tb_vedic_mult_pipe;
   logic clk = 1'b0;
   always #5 clk = ~clk;

`ifdef VEDIC_SIGNED_EN
   localparam bit SIGNED_BUILD = 1'b1;
   logic sig;
`else
   localparam bit SIGNED_BUILD = 1'b0;
`endif

   logic        rst_n;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] a_drv;
   logic [31:0] b_drv;

   logic rdy4, rdy8, rdy16, rdy32;
   logic ov4, ov8, ov16, ov32;
   logic busy4, busy8, busy16, busy32;
   logic [7:0]  p4;
   logic [15:0] p8;
   logic [31:0] p16;
   logic [63:0] p32;

   vedic_mult_pipe #(.WIDTH(4)) u_d4 (
      .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid), .IN_READY(rdy4),
      .A(a_drv[3:0]), .B(b_drv[3:0]),
`ifdef VEDIC_SIGNED_EN
      .SIGNED(sig),
`endif
      .OUT_VALID(ov4), .OUT_READY(out_ready), .P(p4), .BUSY(busy4));

   vedic_mult_pipe #(.WIDTH(8)) u_d8 (
      .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid), .IN_READY(rdy8),
      .A(a_drv[7:0]), .B(b_drv[7:0]),
`ifdef VEDIC_SIGNED_EN
      .SIGNED(sig),
`endif
      .OUT_VALID(ov8), .OUT_READY(out_ready), .P(p8), .BUSY(busy8));

   vedic_mult_pipe #(.WIDTH(16)) u_d16 (
      .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid), .IN_READY(rdy16),
      .A(a_drv[15:0]), .B(b_drv[15:0]),
`ifdef VEDIC_SIGNED_EN
      .SIGNED(sig),
`endif
      .OUT_VALID(ov16), .OUT_READY(out_ready), .P(p16), .BUSY(busy16));

   vedic_mult_pipe #(.WIDTH(32)) u_d32 (
      .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid), .IN_READY(rdy32),
      .A(a_drv), .B(b_drv),
`ifdef VEDIC_SIGNED_EN
      .SIGNED(sig),
`endif
      .OUT_VALID(ov32), .OUT_READY(out_ready), .P(p32), .BUSY(busy32));

   int checks = 0;
   int errors = 0;
   bit rand_mode = 1'b0;
   logic [63:0] q4[$];
   logic [63:0] q8[$];
   logic [63:0] q16[$];
   logic [63:0] q32[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: plain arithmetic multiply of the w-bit operands, 2w-bit result
   function automatic logic [63:0] model(input int w, input logic [31:0] a,
                                         input logic [31:0] b, input logic s);
      logic [63:0] am, bm, m, r;
      longint sa, sb;
      am = {32'b0, a} & ((64'd1 << w) - 64'd1);
      bm = {32'b0, b} & ((64'd1 << w) - 64'd1);
      m  = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2*w)) - 64'd1);
      sa = longint'(am);
      sb = longint'(bm);
      if (s && am[w-1]) sa = sa - longint'(64'd1 << w);
      if (s && bm[w-1]) sb = sb - longint'(64'd1 << w);
      r = 64'(sa * sb);
      return r & m;
   endfunction

   task automatic pop_check(input string name, input logic [63:0] act, inout logic [63:0] q[$]);
      if (q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: got unexpected product %h expected no output", name, act);
      end else begin
         check(name, act, q.pop_front());
      end
   endtask

   // Scoreboard monitor: compares on every output transfer, independent of stimulus
   task automatic monitor();
      forever begin
         @(negedge clk);
         if (rst_n && out_ready) begin
            if (ov4)  pop_check("w4_product",  64'(p4),  q4);
            if (ov8)  pop_check("w8_product",  64'(p8),  q8);
            if (ov16) pop_check("w16_product", 64'(p16), q16);
            if (ov32) pop_check("w32_product", p32,      q32);
         end
      end
   endtask

   task automatic rnd_ready();
      if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [63:0] exp8);
      int n = 0;
      a_drv = a;
      b_drv = b;
`ifdef VEDIC_SIGNED_EN
      sig = s;
`endif
      in_valid = 1'b1;
      @(negedge clk);
      while (!rdy8 && n < 64) begin
         @(posedge clk);
         #1 rnd_ready();
         @(negedge clk);
         n++;
      end
      if (!rdy8) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got IN_READY=0 for %0d cycles expected 1", n);
         in_valid = 1'b0;
      end else begin
         q4.push_back(model(4, a, b, s));
         q8.push_back(exp8);
         q16.push_back(model(16, a, b, s));
         q32.push_back(model(32, a, b, s));
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      rnd_ready();
   endtask

   task automatic idle();
      in_valid = 1'b0;
      @(posedge clk);
      #1 rnd_ready();
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a_drv     = '0;
      b_drv     = '0;
`ifdef VEDIC_SIGNED_EN
      sig       = 1'b0;
`endif
      fork
         monitor();
      join_none

      // Reset state of every instance
      #2;
      check("rst_ov8",   64'(ov8),   64'd0);
      check("rst_p8",    64'(p8),    64'd0);
      check("rst_busy",  64'({busy4, busy8, busy16, busy32}), 64'd0);
      check("rst_ready", 64'({rdy4, rdy8, rdy16, rdy32}),     64'hF);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Single maximal operand pair: product two cycles after the transfer, for one cycle
      send(32'hFF, 32'hFF, 1'b0, 64'hFE01);
      check("lat_busy", 64'(busy8), 64'd1);
      idle();
      check("lat_ov8", 64'(ov8), 64'd1);
      check("lat_p8",  64'(p8),  64'hFE01);
      idle();
      check("lat_ov8_after", 64'(ov8), 64'd0);
      check("lat_p8_hold",   64'(p8),  64'hFE01);
      idle();

      // Back-to-back pairs, including a zero operand
      send(32'd3,  32'd5,   1'b0, 64'd15);
      send(32'd12, 32'd12,  1'b0, 64'd144);
      check("b2b_p8_0", 64'(p8), 64'd15);
      send(32'd0,  32'd200, 1'b0, 64'd0);
      check("b2b_p8_1", 64'(p8), 64'd144);
      idle();
      check("b2b_p8_2", 64'(p8), 64'd0);
      check("b2b_ov8",  64'(ov8), 64'd1);
      idle();
      idle();

      // Stall with two entries in flight
      out_ready = 1'b0;
      send(32'd7,   32'd9, 1'b0, 64'd63);
      send(32'd100, 32'd3, 1'b0, 64'd300);
      for (int i = 0; i < 4; i++) begin
         check("stall_ready", 64'(rdy8), 64'd0);
         check("stall_p8",    64'(p8),   64'd63);
         check("stall_busy",  64'(busy8), 64'd1);
         idle();
      end
      out_ready = 1'b1;
      idle();
      check("drain_p8", 64'(p8), 64'd300);
      idle();
      idle();

      // Reset with two entries in flight discards them
      send(32'h0000_1234, 32'h0000_0100, 1'b0, 64'h0);
      send(32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 64'hFE01);
      q4.delete();
      q8.delete();
      q16.delete();
      q32.delete();
      rst_n = 1'b0;
      #1;
      check("mid_rst_ov16",   64'(ov16),   64'd0);
      check("mid_rst_p16",    64'(p16),    64'd0);
      check("mid_rst_busy16", 64'(busy16), 64'd0);
      check("mid_rst_rdy16",  64'(rdy16),  64'd1);
      @(posedge clk);
      #1 rst_n = 1'b1;
      send(32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 64'hFE01);
      check("post_rst_ov16", 64'(ov16), 64'd0);
      idle();
      check("post_rst_ov16_new", 64'(ov16), 64'd1);
      check("post_rst_p16",      64'(p16),  64'hFFFE_0001);
      idle();

`ifdef VEDIC_SIGNED_EN
      send(32'hFF, 32'h02, 1'b1, 64'hFFFE);
      send(32'hFF, 32'h02, 1'b0, 64'h01FE);
      send(32'h80, 32'h80, 1'b1, 64'h4000);
      send(32'h80, 32'h7F, 1'b1, 64'hC080);
      idle();
      idle();
`endif

      // Random regression with random bubbles and backpressure
      rand_mode = 1'b1;
      for (int i = 0; i < 400; i++) begin
         logic [31:0] ra, rb;
         logic        rs;
         ra = $urandom();
         rb = $urandom();
         if (i % 16 == 0) ra = 32'hFFFF_FFFF;
         rs = SIGNED_BUILD ? 1'($urandom_range(0, 1)) : 1'b0;
         if ($urandom_range(0, 3) != 0) send(ra, rb, rs, model(8, ra, rb, rs));
         else idle();
      end
      rand_mode = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 20 && (q4.size() + q8.size() + q16.size() + q32.size()) != 0; i++)
         idle();
      check("drain_empty", 64'(q4.size() + q8.size() + q16.size() + q32.size()), 64'd0);
      check("final_busy",  64'({busy4, busy8, busy16, busy32}), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
